// File: rtl/udma_i2c_cmd_seq.sv
// udma_i2c_cmd_seq: command sequencer between the uDMA TX/RX byte streams and the I2C bus
// controller. Decodes command bytes, issues one bus op at a time and pushes read bytes to RX.
// Optional feature: define UDMA_I2C_CMD_RPT_EN to enable the RPT (0xC) repeat command.
module udma_i2c_cmd_seq #(
    parameter int unsigned DIV_W = 16,
    parameter int unsigned RPT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cfg_do_rst_i,
    input  logic [7:0]       tx_data_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    output logic [7:0]       rx_data_o,
    output logic             rx_valid_o,
    input  logic             rx_ready_i,
    output logic             op_valid_o,
    output logic [1:0]       op_o,
    output logic [7:0]       op_data_o,
    output logic             op_ack_o,
    input  logic             op_ready_i,
    input  logic             res_valid_i,
    input  logic [7:0]       res_data_i,
    input  logic             al_i,
    output logic [DIV_W-1:0] cfg_div_o,
    output logic             status_busy_o,
    output logic             status_al_o
);

    typedef enum logic [2:0] {
        StIdle, StFetch, StFetchArg, StIssue, StWaitRes, StPushRx, StHalt
    } state_e;

    localparam logic [1:0] OpStart = 2'd0;
    localparam logic [1:0] OpStop  = 2'd1;
    localparam logic [1:0] OpWrite = 2'd2;
    localparam logic [1:0] OpRead  = 2'd3;

    localparam logic [3:0] CmdStart  = 4'h0;
    localparam logic [3:0] CmdStop   = 4'h2;
    localparam logic [3:0] CmdRdAck  = 4'h4;
    localparam logic [3:0] CmdRdNack = 4'h6;
    localparam logic [3:0] CmdWr     = 4'h8;
    localparam logic [3:0] CmdCfg    = 4'hE;
`ifdef UDMA_I2C_CMD_RPT_EN
    localparam logic [3:0] CmdRpt    = 4'hC;
`endif

    localparam logic [RPT_W-1:0] RptOne = RPT_W'(1);

    state_e           state_q;
    logic [3:0]       cmd_q;
    logic [1:0]       op_q;
    logic [7:0]       op_data_q;
    logic             op_ack_q;
    logic             op_valid_q;
    logic [7:0]       rx_data_q;
    logic             rx_valid_q;
    logic [7:0]       div_msb_q;
    logic             arg_hi_q;
    logic             skip_q;
    logic [DIV_W-1:0] cfg_div_q;
    logic [RPT_W-1:0] rpt_cnt_q;
    logic             rpt_arm_q;
    logic             rpt_run_q;
    logic             status_busy_q;
    logic             status_al_q;

    logic skip_cmd;
    logic rpt_more;

    // An armed repeat with count zero swallows the next command; a running repeat continues
    // until the count it is about to decrement reaches one.
    assign skip_cmd = rpt_arm_q && (rpt_cnt_q == '0);
    assign rpt_more = rpt_run_q && (rpt_cnt_q != RptOne);

    // Sequencer FSM with registered bus-op, RX, config and status outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            cmd_q         <= '0;
            op_q          <= OpStart;
            op_data_q     <= '0;
            op_ack_q      <= 1'b0;
            op_valid_q    <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            div_msb_q     <= '0;
            arg_hi_q      <= 1'b0;
            skip_q        <= 1'b0;
            cfg_div_q     <= '0;
            rpt_cnt_q     <= '0;
            rpt_arm_q     <= 1'b0;
            rpt_run_q     <= 1'b0;
            status_busy_q <= 1'b0;
            status_al_q   <= 1'b0;
        end else if (cfg_do_rst_i) begin
            state_q       <= StIdle;
            cmd_q         <= '0;
            op_q          <= OpStart;
            op_data_q     <= '0;
            op_ack_q      <= 1'b0;
            op_valid_q    <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            div_msb_q     <= '0;
            arg_hi_q      <= 1'b0;
            skip_q        <= 1'b0;
            cfg_div_q     <= '0;
            rpt_cnt_q     <= '0;
            rpt_arm_q     <= 1'b0;
            rpt_run_q     <= 1'b0;
            status_busy_q <= 1'b0;
            status_al_q   <= 1'b0;
        end else begin
            status_al_q   <= 1'b0;
            status_busy_q <= (state_q != StIdle) | op_valid_q | rx_valid_q;
            if (al_i) begin
                // Arbitration loss wins over everything, including a coincident result
                state_q     <= StHalt;
                op_valid_q  <= 1'b0;
                rx_valid_q  <= 1'b0;
                rpt_cnt_q   <= '0;
                rpt_arm_q   <= 1'b0;
                rpt_run_q   <= 1'b0;
                status_al_q <= 1'b1;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (tx_valid_i) state_q <= StFetch;
                    end
                    StFetch: begin
                        if (tx_valid_i) begin
                            cmd_q     <= tx_data_i[7:4];
                            rpt_arm_q <= 1'b0;
                            rpt_run_q <= 1'b0;
                            case (tx_data_i[7:4])
                                CmdStart, CmdStop, CmdRdAck, CmdRdNack: begin
                                    op_q     <= (tx_data_i[7:4] == CmdStart) ? OpStart :
                                                (tx_data_i[7:4] == CmdStop)  ? OpStop  : OpRead;
                                    op_ack_q <= (tx_data_i[7:4] == CmdRdNack);
                                    if (!skip_cmd) begin
                                        rpt_run_q  <= rpt_arm_q;
                                        op_valid_q <= 1'b1;
                                        state_q    <= StIssue;
                                    end
                                end
                                CmdWr: begin
                                    rpt_run_q <= rpt_arm_q && !skip_cmd;
                                    skip_q    <= skip_cmd;
                                    state_q   <= StFetchArg;
                                end
                                CmdCfg: begin
                                    arg_hi_q <= 1'b1;
                                    state_q  <= StFetchArg;
                                end
`ifdef UDMA_I2C_CMD_RPT_EN
                                CmdRpt: begin
                                    state_q <= StFetchArg;
                                end
`endif
                                default: ;
                            endcase
                        end else if (!rpt_arm_q) begin
                            state_q <= StIdle;
                        end
                    end
                    StFetchArg: begin
                        if (tx_valid_i) begin
                            case (cmd_q)
                                CmdWr: begin
                                    if (skip_q) begin
                                        skip_q  <= 1'b0;
                                        state_q <= StFetch;
                                    end else begin
                                        op_q       <= OpWrite;
                                        op_data_q  <= tx_data_i;
                                        op_ack_q   <= 1'b0;
                                        op_valid_q <= 1'b1;
                                        state_q    <= StIssue;
                                    end
                                end
                                CmdCfg: begin
                                    if (arg_hi_q) begin
                                        div_msb_q <= tx_data_i;
                                        arg_hi_q  <= 1'b0;
                                    end else begin
                                        cfg_div_q <= DIV_W'({div_msb_q, tx_data_i});
                                        state_q   <= StFetch;
                                    end
                                end
                                default: begin
                                    // Repeat count byte; arms the next command
                                    rpt_cnt_q <= RPT_W'(tx_data_i);
                                    rpt_arm_q <= 1'b1;
                                    state_q   <= StFetch;
                                end
                            endcase
                        end
                    end
                    StIssue: begin
                        if (op_ready_i) begin
                            op_valid_q <= 1'b0;
                            state_q    <= StWaitRes;
                        end
                    end
                    StWaitRes: begin
                        if (res_valid_i) begin
                            if (op_q == OpRead) begin
                                rx_data_q  <= res_data_i;
                                rx_valid_q <= 1'b1;
                                state_q    <= StPushRx;
                            end else begin
                                if (rpt_run_q) rpt_cnt_q <= rpt_cnt_q - RptOne;
                                if (rpt_more) begin
                                    op_valid_q <= (cmd_q != CmdWr);
                                    state_q    <= (cmd_q == CmdWr) ? StFetchArg : StIssue;
                                end else begin
                                    rpt_run_q <= 1'b0;
                                    state_q   <= StFetch;
                                end
                            end
                        end
                    end
                    StPushRx: begin
                        if (rx_ready_i) begin
                            rx_valid_q <= 1'b0;
                            if (rpt_run_q) rpt_cnt_q <= rpt_cnt_q - RptOne;
                            if (rpt_more) begin
                                op_valid_q <= 1'b1;
                                state_q    <= StIssue;
                            end else begin
                                rpt_run_q <= 1'b0;
                                state_q   <= StFetch;
                            end
                        end
                    end
                    StHalt: ;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // Soft reset masks handshakes and status in the very cycle it is raised
    always_comb begin
        tx_ready_o    = !cfg_do_rst_i && (state_q inside {StFetch, StFetchArg, StHalt});
        op_valid_o    = op_valid_q && !cfg_do_rst_i;
        rx_valid_o    = rx_valid_q && !cfg_do_rst_i;
        status_busy_o = status_busy_q && !cfg_do_rst_i;
        status_al_o   = status_al_q && !cfg_do_rst_i;
        rx_data_o     = rx_data_q;
        op_o          = op_q;
        op_data_o     = op_data_q;
        op_ack_o      = op_ack_q;
        cfg_div_o     = cfg_div_q;
    end

endmodule
